// File: rtl/inc_dec_sched.sv
//============================================================================
// Module   : inc_dec_sched
// Purpose  : Round-robin scheduler that shares one WIDTH-bit
//            incrementer/decrementer among NREQ requesters. Requests are
//            accepted one at a time, executed in a single cycle and the
//            tagged result is presented on a valid/ready response port.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/op/data   - per-requester request (op 0=inc, 1=dec)
//            req_ready           - one-hot grant, only while idle
//            resp_valid/ready    - response handshake
//            resp_data/carry/id  - result, carry/borrow, owning requester
//            busy                - high while a request is in flight
// Macro    : INC_DEC_SCHED_SAT_EN - when defined, results saturate instead
//            of wrapping; resp_carry still flags the clamp.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module inc_dec_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_carry,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic             r_op;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_carry;
    logic [IDW-1:0]   r_resp_id;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic              w_found;
    logic [IDW-1:0]    w_win;
    logic [WIDTH-1:0]  w_a;
    logic              w_op;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_res;
    logic              w_cout;
    logic [IDW-1:0]    w_ptr_next;

    // Arbitration: rotate the valid vector so the pointer position sits at
    // bit 0, then take the lowest set bit. The doubled vector makes the
    // rotation a plain shift.
    always_comb begin
        w_dbl   = {req_valid, req_valid} >> r_ptr;
        w_rot   = w_dbl[NREQ-1:0];
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Operand/op mux for the winning requester.
    always_comb begin
        w_a  = '0;
        w_op = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == IDW'(k)) begin
                w_a  = req_data[k*WIDTH +: WIDTH];
                w_op = req_op[k];
            end
        end
    end

    // Shared arithmetic unit. The extra MSB is the carry on increment and
    // the borrow on decrement (0 - 1 sets it).
    always_comb begin
        if (r_op) begin
            w_sum = {1'b0, r_a} - (WIDTH+1)'(1);
        end else begin
            w_sum = {1'b0, r_a} + (WIDTH+1)'(1);
        end
        w_cout = w_sum[WIDTH];
        w_res  = w_sum[WIDTH-1:0];
`ifdef INC_DEC_SCHED_SAT_EN
        if (w_cout) begin
            w_res = r_op ? '0 : '1;
        end
`endif
    end

    assign w_ptr_next = (r_resp_id == IDW'(NREQ-1)) ? '0 : r_resp_id + IDW'(1);

    // Grant is combinational so a requester sees it in the same cycle.
    assign req_ready = (r_state == S_IDLE && !rst && w_found)
                       ? (NREQ'(1) << w_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_op         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_carry <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= w_a;
                        r_op    <= w_op;
                        r_id    <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_resp_data  <= w_res;
                    r_resp_carry <= w_cout;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_ptr        <= w_ptr_next;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_carry = r_resp_carry;
    assign resp_id    = r_resp_id;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_inc_dec_sched.sv
//============================================================================
// Module   : tb_inc_dec_sched
// Purpose  : Directed self-checking bench for inc_dec_sched. Grants push the
//            hand-computed expected response into a scoreboard; a monitor
//            pops and compares on every response handshake.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_inc_dec_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_carry;
    logic [IDW-1:0]        resp_id;
    logic                  busy;

    inc_dec_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_carry(resp_carry),
        .resp_id   (resp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
        logic             carry;
    } exp_t;

    exp_t sb[$];
    exp_t pend[$];
    int   errors = 0;
    int   checks = 0;
    int   last_grant = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int id, input logic [WIDTH-1:0] data, input logic carry);
        exp_t e;
        e.id    = IDW'(id);
        e.data  = data;
        e.carry = carry;
        pend.push_back(e);
    endtask

    // Wait for n grants; each must match the next pending expectation.
    task automatic run_grants(input int n, input int spacing);
        int   got;
        int   idle;
        exp_t e;
        got  = 0;
        idle = 0;
        while (got < n) begin
            @(negedge clk);
            if (req_ready != '0) begin
                e = pend.pop_front();
                chk("grant_onehot", {28'd0, req_ready}, 32'd1 << e.id);
                if (spacing > 0 && got > 0) chk("grant_spacing", cyc - last_grant, spacing);
                last_grant = cyc;
                sb.push_back(e);
                got++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_timeout: got %0d grants expected %0d", got, n);
                    pend.delete();
                    req_valid = '0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic drain;
        int k;
        k = 0;
        while (sb.size() > 0 && k < 30) begin
            tick();
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Response monitor: every handshake must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got id=%0d data=%0h expected none", resp_id, resp_data);
            end else begin
                e = sb.pop_front();
                chk("resp_id", {30'd0, resp_id}, {30'd0, e.id});
                chk("resp_data", {28'd0, resp_data}, {28'd0, e.data});
                chk("resp_carry", {31'd0, resp_carry}, {31'd0, e.carry});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0001;
        req_op     = 4'b0000;
        req_data   = {4'h0, 4'h0, 4'h0, 4'h5};
        resp_ready = 1'b1;

        // Reset state, with a request already pending.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_data", {28'd0, resp_data}, 32'd0);
        chk("rst_resp_carry", {31'd0, resp_carry}, 32'd0);
        chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First request: 5+1 = 6, latency of two cycles.
        expect_grant(0, 4'h6, 1'b0);
        run_grants(1, 0);
        chk("lat_exec_valid", {31'd0, resp_valid}, 32'd0);
        chk("lat_exec_busy", {31'd0, busy}, 32'd1);
        chk("lat_exec_ready", {28'd0, req_ready}, 32'd0);
        tick();
        chk("lat_resp_valid", {31'd0, resp_valid}, 32'd1);
        drain();

        // Wrap / saturation boundaries.
        req_valid = 4'b0010;
        req_op    = 4'b0000;
        req_data  = {4'h0, 4'h0, 4'hF, 4'h0};
`ifdef INC_DEC_SCHED_SAT_EN
        expect_grant(1, 4'hF, 1'b1);
`else
        expect_grant(1, 4'h0, 1'b1);
`endif
        run_grants(1, 0);
        drain();

        req_valid = 4'b0100;
        req_op    = 4'b0100;
        req_data  = {4'h0, 4'h0, 4'h0, 4'h0};
`ifdef INC_DEC_SCHED_SAT_EN
        expect_grant(2, 4'h0, 1'b1);
`else
        expect_grant(2, 4'hF, 1'b1);
`endif
        run_grants(1, 0);
        drain();

        // Fairness: pointer at 3, valid 0101 -> 0, then 2, then 0.
        req_valid = 4'b0101;
        req_op    = 4'b0001;
        req_data  = {4'h0, 4'h9, 4'h0, 4'h7};
        expect_grant(0, 4'h6, 1'b0);
        expect_grant(2, 4'hA, 1'b0);
        expect_grant(0, 4'h6, 1'b0);
        run_grants(3, 3);
        drain();

        // Reset during EXEC discards the in-flight request.
        req_valid = 4'b0010;
        req_op    = 4'b0000;
        req_data  = {4'h0, 4'h0, 4'h2, 4'h0};
        @(negedge clk);
        chk("abort_grant", {28'd0, req_ready}, 32'd2);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("abort_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("abort_resp_valid2", {31'd0, resp_valid}, 32'd0);

        req_valid = 4'b1000;
        req_op    = 4'b1000;
        req_data  = {4'h8, 4'h0, 4'h0, 4'h0};
        expect_grant(3, 4'h7, 1'b0);
        run_grants(1, 0);
        drain();

        // All requesters valid, pointer at 0: ids 0,1,2,3,0 every 3 cycles.
        req_valid = 4'b1111;
        req_op    = 4'b0000;
        req_data  = {4'h3, 4'h2, 4'h1, 4'h0};
        expect_grant(0, 4'h1, 1'b0);
        expect_grant(1, 4'h2, 1'b0);
        expect_grant(2, 4'h3, 1'b0);
        expect_grant(3, 4'h4, 1'b0);
        expect_grant(0, 4'h1, 1'b0);
        run_grants(5, 3);
        drain();

        // Backpressure: response held for 5 cycles, new request blocked.
        resp_ready = 1'b0;
        req_valid  = 4'b0010;
        req_op     = 4'b0000;
        req_data   = {4'h0, 4'h5, 4'h3, 4'h0};
        expect_grant(1, 4'h4, 1'b0);
        run_grants(1, 0);
        tick();
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_data", {28'd0, resp_data}, 32'h4);
            chk("bp_id", {30'd0, resp_id}, 32'd1);
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        expect_grant(2, 4'h6, 1'b0);
        run_grants(1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
